conv_tile_writeback: RTL and testbench
======================================

# conv_tile_writeback

- Drains 8x8 result tiles from the convolution datapath and writes them back into a raster-ordered image memory.
- Writes one 16-bit pixel per handshake, walking tiles left-to-right, top-to-bottom across the image.
- This is the write-side counterpart of the controller's tile-gather path: that path reads 8x8 windows out of the image buffer at stride 8; this block puts 8x8 results back at the same positions.
- Sits between the convolution unit's 64-pixel output and the image/feature-map memory write port.

## Interface
Parameters:
- IMG_W, 224: row pitch of the destination image, in pixels.
- TILES_X, 27: tiles per image row (216/8).
- TILES_Y, 27: tile rows per image.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin an image pass; sampled only in IDLE.
- base_addr  in  32  pixel address of image (0,0); latched on the start cycle.
- tile_valid  in  1  tile_data holds a result tile.
- tile_data  in  64x16  packed tile; element k = row k/8, col k%8; element 0 is in bits [15:0].
- tile_ready  out  1  tile accepted when tile_valid && tile_ready.
- wr_valid  out  1  memory write request.
- wr_addr  out  32  pixel address.
- wr_data  out  16  pixel value.
- wr_ready  in  1  memory accepts the write when wr_valid && wr_ready.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse at the end of a pass.

## Operation
States: IDLE, WAIT_TILE, DRAIN, DONE.

- **IDLE**
  - On start: latch base_addr, set tx=0, ty=0, row_base=base_addr, go to WAIT_TILE.
  - tile_valid is ignored.
- **WAIT_TILE**
  - tile_ready=1.
  - On handshake: register all 64 pixels into tile_reg, set k=0, go to DRAIN.
- **DRAIN**
  - wr_valid=1, wr_data=tile_reg[k].
  - wr_addr = row_base + (k/8)*IMG_W + tx*8 + k%8, modulo 2^32.
  - On a write handshake, k increments.
  - On the handshake with k=63:
    - If tx = TILES_X-1: tx=0, ty increments, row_base += 8*IMG_W.
    - Otherwise tx increments.
    - If this was the last tile (tx=TILES_X-1 and ty=TILES_Y-1), go to DONE; otherwise go to WAIT_TILE.
- **DONE**
  - done=1 for one cycle, then go to IDLE.

General rules:
- busy=1 in WAIT_TILE and DRAIN only.
- Addresses are computed incrementally (adders only, no general multipliers).
- IMG_W*8 is a constant.
- wr_addr, wr_data and wr_valid stay stable while wr_valid && !wr_ready.
- tile_data changes while tile_ready=0 have no effect.
- start outside IDLE is ignored; there is no restart mid-pass.
- reset in any state: go to IDLE, clear k/tx/ty, deassert all outputs the same cycle the reset is sampled; the aborted tile is dropped with no further writes.
- wr_ready asserted while wr_valid=0 has no effect.

## Timing
- Reset values: tile_ready=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0.
- start at cycle S: busy=1 and tile_ready=1 at S+1.
- Tile accepted at cycle N: tile_ready=0 and wr_valid=1 with pixel 0 at N+1.
- With wr_ready held high: writes occur at N+1..N+64, tile_ready=1 again at N+65, giving 65 cycles per tile.
- Each cycle of wr_ready=0 adds exactly one cycle.
- Last write handshake of the last tile at cycle L: done=1 and busy=0 at L+1; back in IDLE at L+2, where start is accepted.
- Accepted tile_data is registered, so the producer may change it the cycle after the handshake.

## Test plan
- **Single tile, default params, base_addr=0x1000, tile element k = k+1, wr_ready=1** -> 64 writes; first (0x1000, 1), 9th (0x1000+224, 9), last (0x1000+7*224+7, 64); tile_ready back at accept+65.
- **Tile advance, TILES_X=2, TILES_Y=2, IMG_W=16, base=0** -> tile 1 first addr 8; tile 2 first addr 128; tile 3 last addr 8*16+7*16+15=255; done pulses one cycle after the 256th write, busy falls the same cycle.
- **Backpressure: wr_ready toggles 1,0,1,0** -> wr_addr/wr_data hold during stalls; exactly 64 distinct ordered writes; tile_ready stays 0 throughout DRAIN.
- **Address wrap: base_addr=0xFFFF_FFF8, IMG_W=16** -> pixel (0,8) is out of tile, so check pixel (1,0) addr 0x0000_0008; no X/overflow.
- **Protocol misuse: start pulsed in DRAIN, tile_valid held in IDLE** -> no restart, no tile accepted in IDLE, pass completes normally.
- **Reset at k=30 of tile 5** -> next cycle wr_valid=0, busy=0; no further writes; a new start is accepted and begins at tile (0,0) with addr base.

Source files
------------

// File: rtl/conv_tile_writeback.sv
// Drains 8x8 result tiles into a raster-ordered image memory, one 16-bit pixel
// per write handshake, walking tiles left-to-right, top-to-bottom.
//
// state     | meaning
// IDLE      | waiting for start; tile_valid ignored
// WAIT_TILE | tile_ready high, waiting for the next result tile
// DRAIN     | writing tile_reg pixel k to memory
// DONE      | one-cycle done pulse, then back to IDLE
module conv_tile_writeback #(
    parameter int IMG_W   = 224,
    parameter int TILES_X = 27,
    parameter int TILES_Y = 27
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   base_addr,
    input  logic          tile_valid,
    input  logic [1023:0] tile_data,
    output logic          tile_ready,
    output logic          wr_valid,
    output logic [31:0]   wr_addr,
    output logic [15:0]   wr_data,
    input  logic          wr_ready,
    output logic          busy,
    output logic          done
);
    localparam int TXW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TYW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam logic [TXW-1:0] TX_LAST  = TXW'(TILES_X - 1);
    localparam logic [TYW-1:0] TY_LAST  = TYW'(TILES_Y - 1);
    localparam logic [31:0]    LINE_STEP = 32'(IMG_W);
    localparam logic [31:0]    BAND_STEP = 32'(IMG_W * 8);

    typedef enum logic [1:0] {IDLE, WAIT_TILE, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [1023:0]   tile_reg;
    logic [5:0]      k;
    logic [TXW-1:0]  tx;
    logic [TYW-1:0]  ty;
    logic [31:0]     row_base;   // address of pixel (0,0) of the current tile row
    logic [31:0]     tile_base;  // row_base + tx*8
    logic [31:0]     line_addr;  // tile_base + (k/8)*IMG_W

    logic last_pix, last_col, last_tile, wr_hs;

    assign last_pix  = (k == 6'd63);
    assign last_col  = (tx == TX_LAST);
    assign last_tile = last_col && (ty == TY_LAST);
    assign wr_hs     = (state == DRAIN) && wr_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        tile_ready = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = 32'd0;
        wr_data    = 16'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_TILE;
            end
            WAIT_TILE: begin
                tile_ready = 1'b1;
                busy       = 1'b1;
                if (tile_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                wr_valid = 1'b1;
                busy     = 1'b1;
                wr_addr  = line_addr + {29'd0, k[2:0]};
                wr_data  = tile_reg[{k, 4'b0000} +: 16];
                if (wr_ready && last_pix) state_nxt = last_tile ? DONE : WAIT_TILE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tile storage needs no reset: it is only read in DRAIN after a fresh load.
    always_ff @(posedge clk) begin
        if (state == WAIT_TILE && tile_valid) tile_reg <= tile_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= 6'd0;
            tx        <= '0;
            ty        <= '0;
            row_base  <= 32'd0;
            tile_base <= 32'd0;
            line_addr <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tx        <= '0;
                        ty        <= '0;
                        row_base  <= base_addr;
                        tile_base <= base_addr;
                    end
                end
                WAIT_TILE: begin
                    if (tile_valid) begin
                        k         <= 6'd0;
                        line_addr <= tile_base;
                    end
                end
                DRAIN: begin
                    if (wr_hs) begin
                        k <= k + 6'd1;
                        if (k[2:0] == 3'd7) line_addr <= line_addr + LINE_STEP;
                        if (last_pix) begin
                            if (last_col) begin
                                tx        <= '0;
                                ty        <= ty + 1'b1;
                                row_base  <= row_base + BAND_STEP;
                                tile_base <= row_base + BAND_STEP;
                            end else begin
                                tx        <= tx + 1'b1;
                                tile_base <= tile_base + 32'd8;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_tile_writeback.sv
// Self-checking bench for conv_tile_writeback: random tiles and backpressure
// checked against an arithmetic address/data model of the image layout.
module tb_conv_tile_writeback;
    localparam int W  = 16;
    localparam int TX = 2;
    localparam int TY = 2;
    localparam int NT = TX * TY;

    logic          clk = 1'b0;
    logic          reset, start, tile_valid, wr_ready;
    logic [31:0]   base_addr;
    logic [1023:0] tile_data;
    logic          tile_ready, wr_valid, busy, done;
    logic [31:0]   wr_addr;
    logic [15:0]   wr_data;

    conv_tile_writeback #(.IMG_W(W), .TILES_X(TX), .TILES_Y(TY)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .tile_valid(tile_valid), .tile_data(tile_data), .tile_ready(tile_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int acc_cyc;
    logic [15:0] pix [64];
    logic [31:0] got_a [$];
    logic [15:0] got_d [$];
    logic [31:0] first_a [NT];
    logic [31:0] ninth_a [NT];
    logic [31:0] last_a  [NT];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pixel (ty*8 + k/8, tx*8 + k%8) of a raster image with pitch W.
    function automatic logic [31:0] exp_addr(input logic [31:0] b, input int t, input int k);
        logic [63:0] a;
        a = 64'(b) + 64'(((t / TX) * 8 + k / 8) * W + (t % TX) * 8 + k % 8);
        return a[31:0];
    endfunction

    task automatic load_tile(input int t);
        for (int k = 0; k < 64; k++) begin
            pix[k] = (t == 0) ? 16'(k + 1) : 16'($urandom);
            tile_data[k*16 +: 16] = pix[k];
        end
    endtask

    task automatic send_tile();
        int g;
        g = 0;
        tile_valid = 1'b1;
        while (!tile_ready && g < 20) begin
            tick();
            g++;
        end
        chk("tile_ready_wait", {47'd0, tile_ready}, 48'd1);
        tick();
        acc_cyc = cyc;
        tile_valid = 1'b0;
        for (int i = 0; i < 32; i++) tile_data[i*32 +: 32] = $urandom;
    endtask

    task automatic drain(input int mode, input int stop_at, input bit poke, output int n, output int st);
        logic [31:0] pa;
        logic [15:0] pd;
        bit ps, saw_tr;
        int g;
        n = 0; st = 0; g = 0; ps = 0; saw_tr = 0; pa = 0; pd = 0;
        got_a.delete();
        got_d.delete();
        while (n < stop_at && g < 600) begin
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (g % 2 == 0);
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke && (g == 5);
            if (poke) base_addr = 32'hDEAD_0000;
            #1;
            if (!wr_ready) st++;
            if (tile_ready) saw_tr = 1;
            if (ps) begin
                chk("stall_valid", {47'd0, wr_valid}, 48'd1);
                chk("stall_addr", {16'd0, wr_addr}, {16'd0, pa});
                chk("stall_data", {32'd0, wr_data}, {32'd0, pd});
            end
            ps = wr_valid && !wr_ready;
            pa = wr_addr;
            pd = wr_data;
            if (wr_valid && wr_ready) begin
                got_a.push_back(wr_addr);
                got_d.push_back(wr_data);
                n++;
            end
            @(posedge clk);
            #1;
            g++;
        end
        start = 1'b0;
        wr_ready = 1'b0;
        chk("tile_ready_low_in_drain", {47'd0, saw_tr}, 48'd0);
    endtask

    task automatic check_tile(input logic [31:0] b, input int t, input int cnt);
        chk($sformatf("write_count_t%0d", t), 48'(got_a.size()), 48'(cnt));
        for (int k = 0; k < cnt && k < got_a.size(); k++) begin
            chk($sformatf("wr_addr_t%0d_k%0d", t, k), {16'd0, got_a[k]}, {16'd0, exp_addr(b, t, k)});
            chk($sformatf("wr_data_t%0d_k%0d", t, k), {32'd0, got_d[k]}, {32'd0, pix[k]});
        end
    endtask

    task automatic run_pass(input logic [31:0] b, input int abort_tile);
        int n, st;
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        base_addr = $urandom;
        chk("busy_after_start", {47'd0, busy}, 48'd1);
        chk("tile_ready_after_start", {47'd0, tile_ready}, 48'd1);
        for (int t = 0; t < NT; t++) begin
            load_tile(t);
            send_tile();
            drain(t % 3, (t == abort_tile) ? 30 : 64, t == 2, n, st);
            check_tile(b, t, (t == abort_tile) ? 30 : 64);
            if (n > 8) begin
                first_a[t] = got_a[0];
                ninth_a[t] = got_a[8];
                last_a[t]  = got_a[n-1];
            end
            if (t == abort_tile) return;
            chk($sformatf("tile_cycles_t%0d", t), 48'(cyc - acc_cyc), 48'(64 + st));
            if (t < NT - 1) begin
                chk("tile_ready_after_drain", {47'd0, tile_ready}, 48'd1);
                chk("busy_mid_pass", {47'd0, busy}, 48'd1);
                chk("done_mid_pass", {47'd0, done}, 48'd0);
            end else begin
                chk("done_pulse", {47'd0, done}, 48'd1);
                chk("busy_at_done", {47'd0, busy}, 48'd0);
                chk("wr_valid_at_done", {47'd0, wr_valid}, 48'd0);
                tick();
                chk("done_one_cycle", {47'd0, done}, 48'd0);
                chk("busy_idle", {47'd0, busy}, 48'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; tile_valid = 1'b0; wr_ready = 1'b0;
        base_addr = 32'd0; tile_data = '0;
        tick(); tick(); tick();
        chk("rst_tile_ready", {47'd0, tile_ready}, 48'd0);
        chk("rst_wr_valid", {47'd0, wr_valid}, 48'd0);
        chk("rst_wr_addr", {16'd0, wr_addr}, 48'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 48'd0);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_done", {47'd0, done}, 48'd0);
        reset = 1'b0;
        tick();

        // tile_valid and wr_ready in IDLE must not be accepted
        tile_valid = 1'b1;
        wr_ready = 1'b1;
        load_tile(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_tile_ready", {47'd0, tile_ready}, 48'd0);
            chk("idle_busy", {47'd0, busy}, 48'd0);
            chk("idle_wr_valid", {47'd0, wr_valid}, 48'd0);
        end
        tile_valid = 1'b0;
        wr_ready = 1'b0;

        run_pass(32'h0000_1000, -1);
        chk("t0_first_addr", {16'd0, first_a[0]}, 48'h1000);
        chk("t0_ninth_addr", {16'd0, ninth_a[0]}, 48'h1000 + W);
        chk("t0_last_addr", {16'd0, last_a[0]}, 48'h1000 + 7 * W + 7);

        // start taken right away in IDLE two cycles after the last write
        run_pass(32'h0000_0000, -1);
        chk("t1_first_addr", {16'd0, first_a[1]}, 48'd8);
        chk("t2_first_addr", {16'd0, first_a[2]}, 48'd128);
        chk("t3_last_addr", {16'd0, last_a[3]}, 48'd255);

        run_pass(32'hFFFF_FFF8, 1);
        chk("wrap_ninth_addr", {16'd0, ninth_a[0]}, 48'h0000_0008);
        reset = 1'b1;
        tick();
        chk("abort_wr_valid", {47'd0, wr_valid}, 48'd0);
        chk("abort_busy", {47'd0, busy}, 48'd0);
        chk("abort_tile_ready", {47'd0, tile_ready}, 48'd0);
        chk("abort_done", {47'd0, done}, 48'd0);
        chk("abort_wr_addr", {16'd0, wr_addr}, 48'd0);
        reset = 1'b0;
        tile_valid = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_abort_no_write", {47'd0, wr_valid}, 48'd0);
            chk("post_abort_tile_ready", {47'd0, tile_ready}, 48'd0);
        end
        tile_valid = 1'b0;
        wr_ready = 1'b0;

        rb = $urandom;
        run_pass(rb, -1);
        chk("restart_first_addr", {16'd0, first_a[0]}, {16'd0, rb});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
